// File: rtl/instr_encoder.sv
// instr_encoder: turns compact MIPS op requests into 32-bit instruction words,
// buffers them in a small FIFO and streams them with an auto-incrementing address.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [15:0]       word_cnt
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  // Bit 32 flags a legal op; bits 31:0 hold the encoded instruction word.
  function automatic logic [32:0] encode_op(
    input logic [3:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [15:0] f_imm
  );
    logic [32:0] res;
    res = {1'b0, 32'h0000_0000};
    case (op)
      4'd0:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
      4'd1:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h22};
      4'd2:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h24};
      4'd3:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h25};
      4'd4:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h27};
      4'd5:    res = {1'b1, 6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h26};
      4'd6:    res = {1'b1, 6'h23, f_rs, f_rt, f_imm};
      4'd7:    res = {1'b1, 6'h2B, f_rs, f_rt, f_imm};
      4'd8:    res = {1'b1, 6'h08, f_rs, f_rt, f_imm};
      default: res = {1'b0, 32'h0000_0000};
    endcase
    return res;
  endfunction

  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [31:0]       fifo_r [DEPTH];
  logic [ADDR_W-1:0] addr_r;
  logic              err_r;
  logic [7:0]        err_cnt_r;
  logic [15:0]       word_cnt_r;

  logic [32:0]       enc_s;
  logic [PTR_W-1:0]  count_s;
  logic              accept_s;
  logic              push_s;
  logic              illegal_s;
  logic              pop_s;

  // Handshake and outputs are all derived from registered state only.
  always_comb begin
    enc_s     = encode_op(op_sel, rs, rt, rd, imm);
    count_s   = wptr_r - rptr_r;
    in_ready  = (count_s < DEPTH_P);
    mem_valid = (count_s != {PTR_W{1'b0}});
    accept_s  = in_valid && in_ready;
    push_s    = accept_s && enc_s[32];
    illegal_s = accept_s && !enc_s[32];
    pop_s     = mem_valid && mem_ready;
    mem_data  = fifo_r[rptr_r[IDX_W-1:0]];
    mem_addr  = addr_r;
    err       = err_r;
    err_cnt   = err_cnt_r;
    word_cnt  = word_cnt_r;
  end

  // FIFO pointers, storage, write address and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r     <= {PTR_W{1'b0}};
      rptr_r     <= {PTR_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      err_r      <= 1'b0;
      err_cnt_r  <= 8'd0;
      word_cnt_r <= 16'd0;
    end else begin
      if (push_s) begin
        fifo_r[wptr_r[IDX_W-1:0]] <= enc_s[31:0];
        wptr_r                    <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r     <= rptr_r + PTR_W'(1);
        word_cnt_r <= word_cnt_r + 16'd1;
      end
      // A load coinciding with a transfer wins: the next address is addr_base itself.
      if (addr_load) begin
        addr_r <= addr_base;
      end else if (pop_s) begin
        addr_r <= addr_r + ADDR_W'(1);
      end
      err_r <= illegal_s;
      if (illegal_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_base;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              err;
  logic [7:0]        err_cnt;
  logic [15:0]       word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .addr_load(addr_load), .addr_base(addr_base),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .err(err), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoding computed from field positions with plain arithmetic.
  function automatic logic [31:0] enc_ref(input int op, input int f_rs, input int f_rt,
                                          input int f_rd, input int f_imm);
    longint w;
    longint code;
    case (op)
      0: code = 32;  1: code = 34;  2: code = 36;
      3: code = 37;  4: code = 39;  5: code = 38;
      6: code = 35;  7: code = 43;  8: code = 8;
      default: code = 0;
    endcase
    if (op <= 5)
      w = longint'(f_rs) * 2097152 + longint'(f_rt) * 65536 + longint'(f_rd) * 2048 + code;
    else
      w = code * 67108864 + longint'(f_rs) * 2097152 + longint'(f_rt) * 65536 + longint'(f_imm);
    return w[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; op_sel = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0;
    addr_load = 1'b0; addr_base = 8'd0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int op, input int a, input int b, input int c, input int i);
    in_valid = 1'b1; op_sel = 4'(op); rs = 5'(a); rt = 5'(b); rd = 5'(c); imm = 16'(i);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %0b want 0", mem_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    n_checks++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_add();
    do_reset();
    mem_ready = 1'b1;
    set_req(0, 1, 2, 3, 16'hBEEF);
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b want 1", mem_valid); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL add_addr: got %h want 00", mem_addr); end
    n_checks++; if (mem_data !== 32'h00221820) begin n_fail++; $display("FAIL add_data: got %h want 00221820", mem_data); end
    tick();
    n_checks++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL add_word_cnt: got %0d want 1", word_cnt); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained: got %0b want 0", mem_valid); end
  endtask

  task automatic test_itype();
    logic [31:0] exp_w [3];
    logic [31:0] gw [$];
    logic [7:0]  ga [$];
    int sent;
    exp_w[0] = 32'h8FA80004; exp_w[1] = 32'hAFA9FFFC; exp_w[2] = 32'h20040010;
    sent = 0;
    do_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (mem_valid) begin gw.push_back(mem_data); ga.push_back(mem_addr); end
      case (sent)
        0: set_req(6, 29, 8, 0, 16'h0004);
        1: set_req(7, 29, 9, 0, 16'hFFFC);
        2: set_req(8, 0, 4, 0, 16'h0010);
        default: in_valid = 1'b0;
      endcase
      sent++;
      tick();
    end
    n_checks++; if (gw.size() != 3) begin n_fail++; $display("FAIL itype_count: got %0d want 3", gw.size()); end
    for (int i = 0; i < 3 && i < gw.size(); i++) begin
      n_checks++; if (gw[i] !== exp_w[i]) begin n_fail++; $display("FAIL itype_data[%0d]: got %h want %h", i, gw[i], exp_w[i]); end
      n_checks++; if (ga[i] !== 8'(i)) begin n_fail++; $display("FAIL itype_addr[%0d]: got %h want %h", i, ga[i], i); end
    end
  endtask

  task automatic test_backpressure();
    int bp_op [5];
    logic [31:0] gw [$];
    logic [7:0]  ga [$];
    logic        acc_now;
    int          acc5;
    bp_op[0] = 0; bp_op[1] = 1; bp_op[2] = 2; bp_op[3] = 3; bp_op[4] = 8;
    acc5 = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(bp_op[k], k + 1, k + 5, k + 10, 16'h1000 + k);
      tick();
    end
    set_req(bp_op[4], 5, 9, 14, 16'h1004);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got in_ready %0b want 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (mem_data !== enc_ref(bp_op[0], 1, 5, 10, 16'h1000)) begin n_fail++; $display("FAIL bp_stable: got %h want %h", mem_data, enc_ref(bp_op[0], 1, 5, 10, 16'h1000)); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %0b want 0", in_ready); end
    end
    mem_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (mem_valid && mem_ready) begin gw.push_back(mem_data); ga.push_back(mem_addr); end
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin in_valid = 1'b0; acc5++; end
    end
    n_checks++; if (acc5 != 1) begin n_fail++; $display("FAIL bp_fifth_accept: got %0d want 1", acc5); end
    n_checks++; if (gw.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", gw.size()); end
    for (int i = 0; i < 5 && i < gw.size(); i++) begin
      n_checks++; if (gw[i] !== enc_ref(bp_op[i], i + 1, i + 5, i + 10, 16'h1000 + i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, gw[i], enc_ref(bp_op[i], i + 1, i + 5, i + 10, 16'h1000 + i)); end
      n_checks++; if (ga[i] !== 8'(i)) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h want %h", i, ga[i], i); end
    end
  endtask

  task automatic test_illegal();
    int err_seen;
    int exp_cnt;
    err_seen = 0;
    do_reset();
    mem_ready = 1'b1;
    set_req(12, 1, 2, 3, 0);
    tick();
    in_valid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_pulse: got %0b want 1", err); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL ill_no_push: got %0b want 0", mem_valid); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL ill_err_cnt: got %0d want 1", err_cnt); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_once: got %0b want 0", err); end
    for (int j = 0; j < 300; j++) begin
      set_req($urandom_range(9, 15), $urandom_range(0, 31), 0, 0, 0);
      tick();
      if (err === 1'b1) err_seen++;
      exp_cnt = (j + 2 > 255) ? 255 : j + 2;
      n_checks++; if (err_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL ill_sat[%0d]: got %0d want %0d", j, err_cnt, exp_cnt); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (err_seen != 300) begin n_fail++; $display("FAIL ill_err_b2b: got %0d want 300", err_seen); end
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL ill_err_cnt_final: got %0d want 255", err_cnt); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL ill_empty: got %0b want 0", mem_valid); end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] ga [$];
    logic [7:0] exp_a [3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    do_reset();
    addr_load = 1'b1; addr_base = 8'hFE;
    tick();
    addr_load = 1'b0;
    n_checks++; if (mem_addr !== 8'hFE) begin n_fail++; $display("FAIL wrap_load: got %h want fe", mem_addr); end
    mem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (mem_valid) ga.push_back(mem_addr);
      if (c < 3) set_req(5, c, c + 1, c + 2, 0); else in_valid = 1'b0;
      tick();
    end
    n_checks++; if (ga.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", ga.size()); end
    for (int i = 0; i < 3 && i < ga.size(); i++) begin
      n_checks++; if (ga[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, ga[i], exp_a[i]); end
    end
    n_checks++; if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL wrap_word_cnt: got %0d want 3", word_cnt); end
  endtask

  task automatic test_load_collide();
    do_reset();
    addr_load = 1'b1; addr_base = 8'h05;
    tick();
    addr_load = 1'b0;
    set_req(4, 7, 8, 9, 0);
    tick();
    set_req(6, 3, 4, 0, 16'h0123);
    tick();
    in_valid = 1'b0;
    n_checks++; if (mem_addr !== 8'h05) begin n_fail++; $display("FAIL col_first_addr: got %h want 05", mem_addr); end
    n_checks++; if (mem_data !== enc_ref(4, 7, 8, 9, 0)) begin n_fail++; $display("FAIL col_first_data: got %h want %h", mem_data, enc_ref(4, 7, 8, 9, 0)); end
    mem_ready = 1'b1; addr_load = 1'b1; addr_base = 8'h40;
    tick();
    mem_ready = 1'b0; addr_load = 1'b0;
    n_checks++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL col_word_cnt: got %0d want 1", word_cnt); end
    n_checks++; if (mem_addr !== 8'h40) begin n_fail++; $display("FAIL col_load_wins: got %h want 40", mem_addr); end
    n_checks++; if (mem_data !== enc_ref(6, 3, 4, 0, 16'h0123)) begin n_fail++; $display("FAIL col_second_data: got %h want %h", mem_data, enc_ref(6, 3, 4, 0, 16'h0123)); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_checks++; if (mem_addr !== 8'h41) begin n_fail++; $display("FAIL col_after: got %h want 41", mem_addr); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL col_drained: got %0b want 0", mem_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr_load = 1'b1; addr_base = 8'h33;
    tick();
    addr_load = 1'b0; mem_ready = 1'b1;
    set_req(1, 2, 3, 4, 0);
    tick();
    in_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    set_req(13, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin set_req(2, k, k, k, 0); tick(); end
    in_valid = 1'b0;
    n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered: got %0b want 1", mem_valid); end
    n_checks++; if (mem_addr !== 8'h34) begin n_fail++; $display("FAIL mid_addr_pre: got %h want 34", mem_addr); end
    rst = 1'b1;
    set_req(0, 1, 1, 1, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", mem_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b want 1", in_ready); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL mid_addr: got %h want 00", mem_addr); end
    n_checks++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_word_cnt: got %0d want 0", word_cnt); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
    tick();
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_accept_ignored: got %0b want 0", mem_valid); end
  endtask

  task automatic test_random();
    logic [31:0] m_q [$];
    logic [7:0]  m_addr;
    logic [15:0] m_wc;
    int          m_ec;
    logic        m_err;
    logic        exp_ready;
    do_reset();
    m_addr = 8'd0; m_wc = 16'd0; m_ec = 0; m_err = 1'b0;
    for (int c = 0; c < 600; c++) begin
      n_checks++; if (in_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %0b want %0b", c, in_ready, m_q.size() < DEPTH); end
      n_checks++; if (mem_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", c, mem_valid, m_q.size() != 0); end
      n_checks++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", c, mem_addr, m_addr); end
      if (m_q.size() != 0) begin
        n_checks++; if (mem_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, mem_data, m_q[0]); end
      end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %0b want %0b", c, err, m_err); end
      n_checks++; if (err_cnt !== 8'(m_ec)) begin n_fail++; $display("FAIL rnd_err_cnt@%0d: got %0d want %0d", c, err_cnt, m_ec); end
      n_checks++; if (word_cnt !== m_wc) begin n_fail++; $display("FAIL rnd_word_cnt@%0d: got %0d want %0d", c, word_cnt, m_wc); end
      in_valid  = ($urandom_range(0, 3) != 0);
      op_sel    = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_base = 8'($urandom);
      exp_ready = (m_q.size() < DEPTH);
      if (m_q.size() != 0 && mem_ready) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 8'd1;
        m_wc   = m_wc + 16'd1;
      end
      if (addr_load) m_addr = addr_base;
      m_err = 1'b0;
      if (in_valid && exp_ready) begin
        if (op_sel <= 4'd8) m_q.push_back(enc_ref(op_sel, rs, rt, rd, imm));
        else begin m_err = 1'b1; if (m_ec < 255) m_ec++; end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_itype();
    test_backpressure();
    test_illegal();
    test_addr_wrap();
    test_load_collide();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
